// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store unit: access modes, FSM states, byte-lane masks.
// Lane masks are expressed for a 32-bit word (four byte lanes, lane 0 = bits 7:0).
package dmem_pkg;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_BYTE = 2'b10;
    localparam logic [1:0] MODE_INV  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    localparam logic [3:0] LANES_BYTE = 4'b0001;
    localparam logic [3:0] LANES_HALF = 4'b0011;
    localparam logic [3:0] LANES_WORD = 4'b1111;

    function automatic logic [3:0] mode_lanes(input logic [1:0] mode);
        case (mode)
            MODE_WORD: mode_lanes = LANES_WORD;
            MODE_HALF: mode_lanes = LANES_HALF;
            MODE_BYTE: mode_lanes = LANES_BYTE;
            default:   mode_lanes = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [1:0]  mode,
                                                input logic        uns);
        case (mode)
            MODE_BYTE: load_extend = uns ? {24'h000000, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            MODE_HALF: load_extend = uns ? {16'h0000, raw[15:0]}   : {{16{raw[15]}}, raw[15:0]};
            default:   load_extend = raw;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised RAM: per-byte-lane write enable, registered read (data valid the cycle after i_re),
// synchronous clear of every word and the read register while rst is high.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DW = 32,
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    i_we,
    input  logic          i_re,
    input  logic [IW-1:0] i_idx,
    input  logic [DW-1:0] i_wdat,
    output logic [DW-1:0] o_rdat
);

    localparam int DEPTH  = 1 << IW;
    localparam int NLANES = $bits(LANES_WORD);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdat;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdat <= '0;
        end else begin
            for (int b = 0; b < NLANES; b++) begin
                if (i_we[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdat[8*b +: 8];
                end
            end
            if (i_re) begin
                r_rdat <= r_mem[i_idx];
            end
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: byte/half/word access, latency 1 (2 for word-crossing accesses under DMEM_MISALIGNED_EN).
// req_ready is low during the SPLIT second half and while rst is high; without the macro misaligned accesses are rejected.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DMEM_DATA_WIDTH = 32,
    parameter int DMEM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       wr_en,
    input  logic [1:0]                 rw_mode,
    input  logic                       ld_unsigned,
    input  logic [DMEM_ADDR_WIDTH-1:0] addr,
    input  logic [DMEM_DATA_WIDTH-1:0] w_data,
    output logic                       rsp_valid,
    output logic [DMEM_DATA_WIDTH-1:0] r_data,
    output logic                       rsp_err
);

    localparam int DW     = DMEM_DATA_WIDTH;
    localparam int WIDX_W = DMEM_ADDR_WIDTH - 2;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_wr;
    logic [1:0]        r_mode;
    logic              r_uns;
    logic [1:0]        r_off;
    logic [WIDX_W-1:0] r_widx;
    logic [3:0]        r_hi_mask;
    logic [DW-1:0]     r_hi_dat;

    logic              r_rsp_vld;
    logic              r_rsp_err;
    logic              r_rsp_ld;
    logic              r_rsp_split;
    logic [DW-1:0]     r_lo_word;

    logic [1:0]        w_off;
    logic [WIDX_W-1:0] w_idx;
    logic [7:0]        w_lanes8;
    logic [2*DW-1:0]   w_dat2;
    logic              w_err;
    logic              w_cross;
    logic              w_acc;

    logic [3:0]        w_bank_we;
    logic              w_bank_re;
    logic [WIDX_W-1:0] w_bank_idx;
    logic [DW-1:0]     w_bank_wdat;
    logic [DW-1:0]     w_bank_rdat;

    logic [2*DW-1:0]   w_ld_src;
    logic [DW-1:0]     w_ld_raw;

    assign w_off = addr[1:0];
    assign w_idx = addr[DMEM_ADDR_WIDTH-1:2];

    // Lanes and data laid across two words: low nibble/word for this word, high for the next one.
    assign w_lanes8 = {4'b0000, mode_lanes(rw_mode)} << w_off;
    assign w_dat2   = {{DW{1'b0}}, w_data} << {w_off, 3'b000};

`ifdef DMEM_MISALIGNED_EN
    assign w_err   = (rw_mode == MODE_INV);
    assign w_cross = |w_lanes8[7:4];
`else
    assign w_err   = (rw_mode == MODE_INV)
                   || ((rw_mode == MODE_HALF) && w_off[0])
                   || ((rw_mode == MODE_WORD) && (w_off != 2'b00));
    assign w_cross = 1'b0;
`endif

    assign w_acc = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        w_bank_we   = 4'b0000;
        w_bank_re   = 1'b0;
        w_bank_idx  = w_idx;
        w_bank_wdat = w_dat2[DW-1:0];
        case (r_state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst && !w_err) begin
                    w_bank_we = wr_en ? w_lanes8[3:0] : 4'b0000;
                    w_bank_re = !wr_en;
                    if (w_cross) begin
                        w_state_nxt = SPLIT;
                    end
                end
            end
            SPLIT: begin
                w_bank_idx  = r_widx;
                w_bank_wdat = r_hi_dat;
                w_bank_we   = r_wr ? r_hi_mask : 4'b0000;
                w_bank_re   = !r_wr;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request fields are held from acceptance until the response, so SPLIT ignores the live inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr      <= 1'b0;
            r_mode    <= MODE_WORD;
            r_uns     <= 1'b0;
            r_off     <= 2'b00;
            r_widx    <= '0;
            r_hi_mask <= 4'b0000;
            r_hi_dat  <= '0;
        end else if (w_acc) begin
            r_wr      <= wr_en;
            r_mode    <= rw_mode;
            r_uns     <= ld_unsigned;
            r_off     <= w_off;
            r_widx    <= w_idx + 1'b1;
            r_hi_mask <= w_lanes8[7:4];
            r_hi_dat  <= w_dat2[2*DW-1:DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_vld   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_ld    <= 1'b0;
            r_rsp_split <= 1'b0;
            r_lo_word   <= '0;
        end else begin
            r_rsp_vld <= 1'b0;
            if (r_state == SPLIT) begin
                r_rsp_vld   <= 1'b1;
                r_rsp_err   <= 1'b0;
                r_rsp_ld    <= !r_wr;
                r_rsp_split <= 1'b1;
                r_lo_word   <= w_bank_rdat;
            end else if (w_acc && !w_cross) begin
                r_rsp_vld   <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_ld    <= !wr_en && !w_err;
                r_rsp_split <= 1'b0;
            end
        end
    end

    dmem_bank #(
        .DW (DW),
        .IW (WIDX_W)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_bank_we),
        .i_re   (w_bank_re),
        .i_idx  (w_bank_idx),
        .i_wdat (w_bank_wdat),
        .o_rdat (w_bank_rdat)
    );

    assign w_ld_src = r_rsp_split ? {w_bank_rdat, r_lo_word} : {{DW{1'b0}}, w_bank_rdat};
    assign w_ld_raw = DW'(w_ld_src >> {r_off, 3'b000});

    assign rsp_valid = r_rsp_vld;
    assign rsp_err   = r_rsp_vld && r_rsp_err;
    assign r_data    = (r_rsp_vld && r_rsp_ld) ? load_extend(w_ld_raw, r_mode, r_uns) : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed cases plus randomized traffic against a byte-array reference model.
// Expectations for misaligned accesses follow DMEM_MISALIGNED_EN when it is defined for the build.
module tb_dmem_lsu;
    import dmem_pkg::*;

    localparam int AW        = 10;
    localparam int MEM_BYTES = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          wr_en;
    logic [1:0]    rw_mode;
    logic          ld_unsigned;
    logic [AW-1:0] addr;
    logic [31:0]   w_data;
    logic          rsp_valid;
    logic [31:0]   r_data;
    logic          rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem_m [MEM_BYTES];

    logic [31:0] o_rd;
    logic        o_err;
    logic        o_rdy0;
    logic        o_rdy1;
    logic        o_va;
    int          o_lat;
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat;

    dmem_lsu #(
        .DMEM_DATA_WIDTH (32),
        .DMEM_ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .wr_en       (wr_en),
        .rw_mode     (rw_mode),
        .ld_unsigned (ld_unsigned),
        .addr        (addr),
        .w_data      (w_data),
        .rsp_valid   (rsp_valid),
        .r_data      (r_data),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Byte-level reference: an access touches n consecutive byte addresses modulo the memory size.
    task automatic model_apply(input logic wr, input logic [1:0] mode, input logic uns,
                               input logic [AW-1:0] a, input logic [31:0] d);
        int n;
        logic [31:0] v;
        bit bad;
        n = (mode == MODE_WORD) ? 4 : (mode == MODE_HALF) ? 2 : (mode == MODE_BYTE) ? 1 : 0;
        bad = (n == 0);
`ifndef DMEM_MISALIGNED_EN
        if (n != 0 && (int'(a) % n) != 0) bad = 1'b1;
`endif
        e_err = bad;
        e_rd  = 32'h0;
        e_lat = (!bad && (int'(a[1:0]) + n > 4)) ? 2 : 1;
        if (!bad) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) begin
                if (wr) mem_m[(int'(a) + i) % MEM_BYTES] = d[8*i +: 8];
                else    v[8*i +: 8] = mem_m[(int'(a) + i) % MEM_BYTES];
            end
            if (!wr) begin
                if (!uns && n < 4 && v[8*n-1]) begin
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
                e_rd = v;
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge one cycle after the response.
    task automatic op(input logic wr, input logic [1:0] mode, input logic uns,
                      input logic [AW-1:0] a, input logic [31:0] d);
        int wt;
        wt = 0;
        req_valid   = 1'b1;
        wr_en       = wr;
        rw_mode     = mode;
        ld_unsigned = uns;
        addr        = a;
        w_data      = d;
        o_rdy0      = req_ready;
        while (!req_ready && wt < 4) begin
            @(negedge clk);
            wt++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wr_en     = 1'($urandom);
        addr      = AW'($urandom);
        w_data    = $urandom;
        o_rdy1    = req_ready;
        o_lat     = 1;
        while (!rsp_valid && o_lat < 6) begin
            @(negedge clk);
            o_lat++;
        end
        o_rd  = r_data;
        o_err = rsp_err;
        @(negedge clk);
        o_va  = rsp_valid;
        model_apply(wr, mode, uns, a, d);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; wr_en = 1'b0; rw_mode = MODE_WORD;
        ld_unsigned = 1'b0; addr = '0; w_data = '0;
        for (int i = 0; i < MEM_BYTES; i++) mem_m[i] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_checks++; if (r_data !== 32'h0) begin n_fail++; $display("FAIL reset_r_data got=%h exp=00000000", r_data); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got=%b exp=1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rsp_valid got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_directed();
        op(1'b0, MODE_WORD, 1'b0, 10'h008, 32'h0);
        n_checks++; if (o_lat !== 1 || o_rd !== 32'h0 || o_err !== 1'b0) begin n_fail++;
            $display("FAIL load_after_reset lat=%0d rd=%h err=%b exp lat=1 rd=00000000 err=0", o_lat, o_rd, o_err); end
        op(1'b1, MODE_BYTE, 1'b0, 10'h005, 32'h0000008F);
        n_checks++; if (o_lat !== 1 || o_err !== 1'b0 || o_rd !== 32'h0) begin n_fail++;
            $display("FAIL store_byte lat=%0d err=%b rd=%h exp lat=1 err=0 rd=0", o_lat, o_err, o_rd); end
        op(1'b0, MODE_BYTE, 1'b0, 10'h005, 32'h0);
        n_checks++; if (o_rd !== 32'hFFFFFF8F) begin n_fail++; $display("FAIL load_byte_signed got=%h exp=ffffff8f", o_rd); end
        op(1'b0, MODE_BYTE, 1'b1, 10'h005, 32'h0);
        n_checks++; if (o_rd !== 32'h0000008F) begin n_fail++; $display("FAIL load_byte_unsigned got=%h exp=0000008f", o_rd); end
        op(1'b0, MODE_WORD, 1'b1, 10'h004, 32'h0);
        n_checks++; if (o_rd !== 32'h00008F00) begin n_fail++; $display("FAIL word_around_byte got=%h exp=00008f00", o_rd); end
        op(1'b1, MODE_WORD, 1'b0, 10'h008, 32'h211E1B18);
        op(1'b1, MODE_HALF, 1'b0, 10'h00A, 32'h0000BEEF);
        op(1'b0, MODE_WORD, 1'b0, 10'h008, 32'h0);
        n_checks++; if (o_rd !== 32'hBEEF1B18) begin n_fail++; $display("FAIL half_merge got=%h exp=beef1b18", o_rd); end
        op(1'b1, MODE_WORD, 1'b0, 10'h000, 32'h12345678);
        op(1'b1, MODE_INV, 1'b0, 10'h000, 32'hDEADBEEF);
        n_checks++; if (o_err !== 1'b1 || o_rd !== 32'h0 || o_lat !== 1) begin n_fail++;
            $display("FAIL invalid_mode err=%b rd=%h lat=%0d exp err=1 rd=0 lat=1", o_err, o_rd, o_lat); end
        op(1'b0, MODE_WORD, 1'b0, 10'h000, 32'h0);
        n_checks++; if (o_rd !== 32'h12345678) begin n_fail++; $display("FAIL invalid_no_write got=%h exp=12345678", o_rd); end
        op(1'b1, MODE_WORD, 1'b0, 10'h00E, 32'hAABBCCDD);
`ifdef DMEM_MISALIGNED_EN
        n_checks++; if (o_lat !== 2 || o_rdy1 !== 1'b0 || o_err !== 1'b0) begin n_fail++;
            $display("FAIL split_store lat=%0d ready=%b err=%b exp lat=2 ready=0 err=0", o_lat, o_rdy1, o_err); end
        op(1'b0, MODE_WORD, 1'b0, 10'h00C, 32'h0);
        n_checks++; if (o_rd !== 32'hCCDD0000) begin n_fail++; $display("FAIL split_low_word got=%h exp=ccdd0000", o_rd); end
        op(1'b0, MODE_WORD, 1'b0, 10'h010, 32'h0);
        n_checks++; if (o_rd !== 32'h0000AABB) begin n_fail++; $display("FAIL split_high_word got=%h exp=0000aabb", o_rd); end
`else
        n_checks++; if (o_lat !== 1 || o_err !== 1'b1 || o_rd !== 32'h0) begin n_fail++;
            $display("FAIL misaligned_reject lat=%0d err=%b rd=%h exp lat=1 err=1 rd=0", o_lat, o_err, o_rd); end
        op(1'b0, MODE_WORD, 1'b0, 10'h00C, 32'h0);
        n_checks++; if (o_rd !== 32'h0) begin n_fail++; $display("FAIL reject_low_word got=%h exp=00000000", o_rd); end
        op(1'b0, MODE_WORD, 1'b0, 10'h010, 32'h0);
        n_checks++; if (o_rd !== 32'h0) begin n_fail++; $display("FAIL reject_high_word got=%h exp=00000000", o_rd); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [3];
        op(1'b1, MODE_WORD, 1'b0, 10'h020, 32'hCAFEF00D);
        op(1'b1, MODE_WORD, 1'b0, 10'h024, 32'h0BADBEEF);
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1;
            wr_en     = 1'b0;
            w_data    = 32'h0;
            case (k)
                0:       begin rw_mode = MODE_WORD; ld_unsigned = 1'b0; addr = 10'h020; end
                1:       begin rw_mode = MODE_BYTE; ld_unsigned = 1'b1; addr = 10'h025; end
                default: begin rw_mode = MODE_HALF; ld_unsigned = 1'b0; addr = 10'h026; end
            endcase
            model_apply(1'b0, rw_mode, ld_unsigned, addr, 32'h0);
            exp_q[k] = e_rd;
            n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, req_ready); end
            if (k > 0) begin
                n_checks++; if (rsp_valid !== 1'b1 || r_data !== exp_q[k-1]) begin n_fail++;
                    $display("FAIL b2b_rsp k=%0d valid=%b rd=%h exp valid=1 rd=%h", k-1, rsp_valid, r_data, exp_q[k-1]); end
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || r_data !== exp_q[2]) begin n_fail++;
            $display("FAIL b2b_rsp k=2 valid=%b rd=%h exp valid=1 rd=%h", rsp_valid, r_data, exp_q[2]); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_strobe_end got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_wrap();
        logic          wr;
        logic [1:0]    mode;
        logic          uns;
        logic [AW-1:0] a;
        logic [31:0]   d;
        for (int k = 0; k < 6; k++) begin
            case (k)
                0:       begin wr = 1'b1; mode = MODE_WORD; uns = 1'b0; a = 10'h3FD; d = 32'h11223344; end
                1:       begin wr = 1'b0; mode = MODE_WORD; uns = 1'b0; a = 10'h3FC; d = 32'h0; end
                2:       begin wr = 1'b0; mode = MODE_WORD; uns = 1'b0; a = 10'h000; d = 32'h0; end
                3:       begin wr = 1'b1; mode = MODE_HALF; uns = 1'b0; a = 10'h3FF; d = 32'h0000BEEF; end
                4:       begin wr = 1'b0; mode = MODE_HALF; uns = 1'b1; a = 10'h3FF; d = 32'h0; end
                default: begin wr = 1'b0; mode = MODE_BYTE; uns = 1'b0; a = 10'h000; d = 32'h0; end
            endcase
            op(wr, mode, uns, a, d);
            n_checks++; if (o_rd !== e_rd || o_err !== e_err || o_lat !== e_lat) begin n_fail++;
                $display("FAIL wrap k=%0d rd=%h err=%b lat=%0d exp rd=%h err=%b lat=%0d", k, o_rd, o_err, o_lat, e_rd, e_err, e_lat); end
        end
    endtask

    task automatic test_random();
        logic          wr;
        logic [1:0]    mode;
        logic          uns;
        logic [AW-1:0] a;
        logic [31:0]   d;
        for (int k = 0; k < 300; k++) begin
            wr   = 1'($urandom_range(0, 1));
            mode = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            d    = $urandom;
            case ($urandom_range(0, 3))
                0:       a = AW'(10'h3F0 + $urandom_range(0, 15));
                1:       a = AW'($urandom_range(0, 15));
                2:       a = AW'(10'h100 + $urandom_range(0, 15));
                default: a = AW'($urandom);
            endcase
            op(wr, mode, uns, a, d);
            n_checks++; if (o_lat !== e_lat) begin n_fail++;
                $display("FAIL rand_latency k=%0d wr=%b mode=%0d addr=%h got=%0d exp=%0d", k, wr, mode, a, o_lat, e_lat); end
            n_checks++; if (o_rd !== e_rd) begin n_fail++;
                $display("FAIL rand_rdata k=%0d wr=%b mode=%0d uns=%b addr=%h got=%h exp=%h", k, wr, mode, uns, a, o_rd, e_rd); end
            n_checks++; if (o_err !== e_err) begin n_fail++;
                $display("FAIL rand_err k=%0d mode=%0d addr=%h got=%b exp=%b", k, mode, a, o_err, e_err); end
            n_checks++; if (o_rdy0 !== 1'b1 || o_rdy1 !== (e_lat == 1)) begin n_fail++;
                $display("FAIL rand_ready k=%0d addr=%h before=%b after=%b exp 1/%b", k, a, o_rdy0, o_rdy1, (e_lat == 1)); end
            n_checks++; if (o_va !== 1'b0) begin n_fail++;
                $display("FAIL rand_strobe_width k=%0d got=%b exp=0", k, o_va); end
        end
    endtask

    task automatic test_split_reset();
        int bad_cycles;
        req_valid = 1'b1; wr_en = 1'b1; rw_mode = MODE_WORD; ld_unsigned = 1'b0;
        addr = 10'h3FE; w_data = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        addr      = 10'h000;
        w_data    = 32'h5A5A5A5A;
`ifdef DMEM_MISALIGNED_EN
        n_checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL split_in_progress ready=%b valid=%b exp ready=0 valid=0", req_ready, rsp_valid); end
`else
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin n_fail++;
            $display("FAIL last_word_reject valid=%b err=%b exp valid=1 err=1", rsp_valid, rsp_err); end
`endif
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ready_during_rst got=%b exp=0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL aborted_split_rsp got=%b exp=0", rsp_valid); end
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_rst_drop got=%b exp=1", req_ready); end
        bad_cycles = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad_cycles++;
        end
        n_checks++; if (bad_cycles !== 0) begin n_fail++;
            $display("FAIL quiet_after_rst cycles_with_activity=%0d exp=0", bad_cycles); end
        for (int i = 0; i < MEM_BYTES; i++) mem_m[i] = 8'h00;
        for (int w = 0; w < MEM_BYTES / 4; w++) begin
            op(1'b0, MODE_WORD, 1'b0, AW'(4 * w), 32'h0);
            n_checks++; if (o_rd !== e_rd || o_err !== 1'b0) begin n_fail++;
                $display("FAIL cleared_word addr=%h got=%h err=%b exp=%h err=0", 4 * w, o_rd, o_err, e_rd); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_wrap();
        test_random();
        test_split_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
